// File: rtl/instr_prefetch_if.sv
// Bus bundle between the instruction prefetcher, its instruction memory and its consumer.
// master: the prefetcher. slave: the memory/consumer side.
interface instr_prefetch_if;

   logic        mem_rd;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [63:0] instr_pc;
   logic        instr_ready;

   modport master (
      output mem_rd,
      output mem_raddr,
      input  mem_rdata,
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_rd,
      input  mem_raddr,
      output mem_rdata,
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one-cycle-latency memory reads buffered in a DEPTH-entry FIFO.
// Define INSTR_PREFETCH_ALIGN_CHECK_EN to halt on misaligned redirects instead of masking them.
module instr_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    redirect,
   input  logic [63:0]             redirect_pc,
   instr_prefetch_if.master        bus,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    misalign
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;
`else
   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   state_t           redirect_state;

   logic [63:0]      fetch_pc;
   logic [63:0]      req_pc;
   logic [63:0]      redirect_target;
   logic             inflight;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W:0]   occupancy;
   logic             issue;
   logic             push;
   logic             pop;

   logic [31:0]      data_mem [DEPTH];
   logic [63:0]      pc_mem   [DEPTH];

   // Reserve a slot for the in-flight read so a response always has room.
   always_comb begin
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
      issue     = (state == FETCH) && !redirect && (occupancy < DEPTH_V);
      push      = inflight && !redirect;
      pop       = bus.instr_valid && bus.instr_ready;
   end

   assign bus.mem_rd      = issue;
   assign bus.mem_raddr   = fetch_pc[31:0];
   assign bus.instr_valid = (count != '0) && !redirect;
   assign bus.instr_data  = data_mem[rd_ptr];
   assign bus.instr_pc    = pc_mem[rd_ptr];

`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
   assign redirect_target = redirect_pc;
`else
   assign redirect_target = redirect_pc & ~64'd3;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_nxt      = state;
      redirect_state = FLUSH;
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
         redirect_state = HALT;
      end
`endif
      case (state)
         FETCH: if (redirect) state_nxt = redirect_state;
         FLUSH: state_nxt = redirect ? redirect_state : FETCH;
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
         HALT:  if (redirect) state_nxt = redirect_state;
`endif
         default: state_nxt = FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_target;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fetch_pc <= fetch_pc + 64'd4;
            req_pc   <= fetch_pc;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately not reset; pointers and count alone define validity.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         data_mem[wr_ptr] <= bus.mem_rdata;
         pc_mem[wr_ptr]   <= req_pc;
      end
   end

`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         misalign <= 1'b0;
      end else if (redirect) begin
         misalign <= (redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign misalign = 1'b0;
`endif

   a_count_bounded: assert property (@(posedge clock) disable iff (reset)
      count <= CNT_W'(DEPTH));

   a_push_has_room: assert property (@(posedge clock) disable iff (reset)
      push |-> ((count < CNT_W'(DEPTH)) || pop));

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: per-cycle checks of fetch/occupancy plus a scoreboard
// of accepted instructions compared by an independent monitor.
module tb_instr_prefetch;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] data;
   } item_t;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   redirect = 1'b0;
   logic [63:0]            redirect_pc = '0;
   logic [$clog2(DEPTH):0] count;
   logic                   misalign;

   item_t exp_q[$];
   int    n_cmp  = 0;
   int    n_bad  = 0;
   int    cyc_no = 0;

   instr_prefetch_if bus ();

   instr_prefetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (64'd0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus),
      .count       (count),
      .misalign    (misalign)
   );

   always #5 clock = ~clock;

   // Memory model: data = address + 0x100, one cycle after the read strobe.
   always @(posedge clock) begin
      bus.mem_rdata <= bus.mem_rd ? (bus.mem_raddr + 32'h100) : 32'hDEAD_BEEF;
   end

   function automatic void expect_instr(input logic [63:0] pc);
      item_t it;
      it.pc   = pc;
      it.data = pc[31:0] + 32'h100;
      exp_q.push_back(it);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted instruction must match the head of the expected queue.
   always @(negedge clock) begin
      if (!reset && bus.instr_valid && bus.instr_ready) begin
         item_t e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_instr@%0d: got pc=%h data=%h, expected nothing",
                     cyc_no, bus.instr_pc, bus.instr_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.instr_pc !== e.pc || bus.instr_data !== e.data) begin
               n_bad++;
               $display("FAIL instr@%0d: got pc=%h data=%h expected pc=%h data=%h",
                        cyc_no, bus.instr_pc, bus.instr_data, e.pc, e.data);
            end
         end
      end
   end

   // Check one cycle mid-period, then advance to just after the next rising edge.
   task automatic step(input logic e_rd, input logic [31:0] e_addr, input int e_cnt,
                       input logic e_vld, input logic e_mis);
      @(negedge clock);
      check($sformatf("mem_rd@%0d", cyc_no), 64'(bus.mem_rd), 64'(e_rd));
      if (e_rd) begin
         check($sformatf("mem_raddr@%0d", cyc_no), 64'(bus.mem_raddr), 64'(e_addr));
      end
      check($sformatf("count@%0d", cyc_no), 64'(count), 64'(e_cnt));
      check($sformatf("instr_valid@%0d", cyc_no), 64'(bus.instr_valid), 64'(e_vld));
      check($sformatf("misalign@%0d", cyc_no), 64'(misalign), 64'(e_mis));
      @(posedge clock);
      #1;
      cyc_no++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      redirect        = 1'b1;
      redirect_pc     = 64'h888;
      bus.instr_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      // Streaming from reset: addresses 0,4,8,... and first instruction two cycles later.
      reset           = 1'b0;
      redirect        = 1'b0;
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) expect_instr(64'(4 * i));
      for (int k = 0; k < 10; k++) step(1'b1, 32'(4 * k), (k >= 2) ? 1 : 0, k >= 2, 1'b0);

      // Back-pressure: exactly four issues, then one pop frees one slot.
      bus.instr_ready = 1'b0;
      redirect        = 1'b1;
      redirect_pc     = 64'h1000;
      step(1'b0, 32'h0, 1, 1'b0, 1'b0);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 32'h1000 + 32'(4 * k), (k < 2) ? 0 : k - 1, k >= 2, 1'b0);
      step(1'b0, 32'h0, 3, 1'b1, 1'b0);
      step(1'b0, 32'h0, 4, 1'b1, 1'b0);
      step(1'b0, 32'h0, 4, 1'b1, 1'b0);
      expect_instr(64'h1000);
      bus.instr_ready = 1'b1;
      step(1'b0, 32'h0, 4, 1'b1, 1'b0);
      bus.instr_ready = 1'b0;
      step(1'b1, 32'h1010, 3, 1'b1, 1'b0);
      step(1'b0, 32'h0, 3, 1'b1, 1'b0);
      step(1'b0, 32'h0, 4, 1'b1, 1'b0);

      // Drain through wrapped pointers while fetch refills.
      for (int i = 1; i <= 6; i++) expect_instr(64'h1000 + 64'(4 * i));
      bus.instr_ready = 1'b1;
      step(1'b0, 32'h0, 4, 1'b1, 1'b0);
      step(1'b1, 32'h1014, 3, 1'b1, 1'b0);
      step(1'b1, 32'h1018, 2, 1'b1, 1'b0);
      step(1'b1, 32'h101C, 2, 1'b1, 1'b0);
      step(1'b1, 32'h1020, 2, 1'b1, 1'b0);
      step(1'b1, 32'h1024, 2, 1'b1, 1'b0);

      // Redirect to 0x200 with count=3 and a read in flight.
      bus.instr_ready = 1'b0;
      redirect        = 1'b1;
      redirect_pc     = 64'h2000;
      step(1'b0, 32'h0, 2, 1'b0, 1'b0);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 32'h2000 + 32'(4 * k), (k < 2) ? 0 : k - 1, k >= 2, 1'b0);
      redirect    = 1'b1;
      redirect_pc = 64'h200;
      step(1'b0, 32'h0, 3, 1'b0, 1'b0);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      expect_instr(64'h200);
      expect_instr(64'h204);
      bus.instr_ready = 1'b1;
      step(1'b1, 32'h200, 0, 1'b0, 1'b0);
      step(1'b1, 32'h204, 0, 1'b0, 1'b0);
      step(1'b1, 32'h208, 1, 1'b1, 1'b0);
      step(1'b1, 32'h20C, 1, 1'b1, 1'b0);

      // Redirect coinciding with a ready consumer and an arriving response.
      expect_instr(64'h400);
      redirect    = 1'b1;
      redirect_pc = 64'h400;
      step(1'b0, 32'h0, 1, 1'b0, 1'b0);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      step(1'b1, 32'h400, 0, 1'b0, 1'b0);
      step(1'b1, 32'h404, 0, 1'b0, 1'b0);
      step(1'b1, 32'h408, 1, 1'b1, 1'b0);

      // 64-bit PC wrap.
      bus.instr_ready = 1'b0;
      redirect        = 1'b1;
      redirect_pc     = 64'hFFFF_FFFF_FFFF_FFFC;
      step(1'b0, 32'h0, 1, 1'b0, 1'b0);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      step(1'b1, 32'hFFFF_FFFC, 0, 1'b0, 1'b0);
      step(1'b1, 32'h0, 0, 1'b0, 1'b0);
      expect_instr(64'hFFFF_FFFF_FFFF_FFFC);
      expect_instr(64'h0);
      bus.instr_ready = 1'b1;
      step(1'b1, 32'h4, 1, 1'b1, 1'b0);
      step(1'b1, 32'h8, 1, 1'b1, 1'b0);

      // Misaligned redirect.
      bus.instr_ready = 1'b0;
      redirect        = 1'b1;
      redirect_pc     = 64'h202;
      step(1'b0, 32'h0, 1, 1'b0, 1'b0);
      redirect = 1'b0;
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
      repeat (5) step(1'b0, 32'h0, 0, 1'b0, 1'b1);
      redirect    = 1'b1;
      redirect_pc = 64'h300;
      step(1'b0, 32'h0, 0, 1'b0, 1'b1);
      redirect = 1'b0;
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      step(1'b1, 32'h300, 0, 1'b0, 1'b0);
      step(1'b1, 32'h304, 0, 1'b0, 1'b0);
      expect_instr(64'h300);
      bus.instr_ready = 1'b1;
      step(1'b1, 32'h308, 1, 1'b1, 1'b0);
`else
      step(1'b0, 32'h0, 0, 1'b0, 1'b0);
      step(1'b1, 32'h200, 0, 1'b0, 1'b0);
      step(1'b1, 32'h204, 0, 1'b0, 1'b0);
      expect_instr(64'h200);
      bus.instr_ready = 1'b1;
      step(1'b1, 32'h208, 1, 1'b1, 1'b0);
`endif

      // Reset beats redirect; the response landing just after release is discarded.
      bus.instr_ready = 1'b0;
      reset           = 1'b1;
      redirect        = 1'b1;
      redirect_pc     = 64'h888;
      @(posedge clock);
      #1;
      redirect = 1'b0;
      @(posedge clock);
      #1;
      reset           = 1'b0;
      bus.instr_ready = 1'b1;
      expect_instr(64'h0);
      expect_instr(64'h4);
      step(1'b1, 32'h0, 0, 1'b0, 1'b0);
      step(1'b1, 32'h4, 0, 1'b0, 1'b0);
      step(1'b1, 32'h8, 1, 1'b1, 1'b0);
      step(1'b1, 32'hC, 1, 1'b1, 1'b0);
      bus.instr_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameters (name, default, meaning):
- DEPTH, 4, FIFO entries, power of two, 2..16.
- RESET_PC, 64'd0, fetch address after reset.
REQ-003 Ports (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- redirect, in, 1, flush and restart fetch at redirect_pc.
- redirect_pc, in, 64, new fetch address.
- mem_rd, out, 1, instruction-memory read strobe.
- mem_raddr, out, 32, read address (fetch_pc[31:0]).
- mem_rdata, in, 32, read data, valid exactly 1 cycle after mem_rd.
- instr_valid, out, 1, FIFO head holds an instruction.
- instr_data, out, 32, head instruction word.
- instr_pc, out, 64, address of head instruction.
- instr_ready, in, 1, consumer accepts head.
- count, out, $clog2(DEPTH)+1, FIFO occupancy.
- misalign, out, 1, sticky misaligned-redirect flag (macro-dependent, REQ-021).

Function
REQ-004 FSM states SHALL be FETCH, FLUSH and HALT; HALT is reachable only with the macro defined.
REQ-005 Issue condition: mem_rd=1 iff state==FETCH, redirect==0, and count+inflight < DEPTH. inflight is a 1-bit register equal to the previous cycle's mem_rd.
REQ-006 On issue, fetch_pc SHALL advance by 4 at the clock edge; 64-bit wrap-around from 0xFFFF_FFFF_FFFF_FFFC to 0 SHALL be silent.
REQ-007 Push: when inflight==1 and redirect==0, {mem_rdata, pc of that request} SHALL be written to the FIFO tail. Push always has space, guaranteed by REQ-005.
REQ-008 instr_valid SHALL equal (count!=0) && !redirect. instr_data and instr_pc SHALL be driven from the head entry combinationally from storage.
REQ-009 Pop SHALL occur when instr_valid && instr_ready. Pop and push in the same cycle SHALL leave count unchanged.
REQ-010 Latency: an issue at cycle t SHALL produce instr_valid=1 at cycle t+2 when the FIFO was empty.
REQ-011 Redirect at cycle t SHALL, in that cycle:
- clear the FIFO (count=0 at t+1);
- drop the response arriving at t;
- suppress issue;
- load fetch_pc=redirect_pc;
- move the FSM to FLUSH.
REQ-012 FLUSH SHALL last one cycle: mem_rd=0, instr_valid=0, then FETCH. A redirect during FLUSH SHALL reload fetch_pc and stay in FLUSH.
REQ-013 Redirect SHALL take priority over push, pop and issue in the same cycle.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-015 With instr_ready held 0, fetch SHALL stop once count+inflight==DEPTH and resume the cycle after the first pop.

Reset
REQ-016 Reset SHALL set fetch_pc=RESET_PC, state=FETCH, inflight=0, count=0 and misalign=0, and empty the FIFO pointers.
REQ-017 Reset SHALL have priority over redirect. Any response arriving in the cycle after reset SHALL be ignored because inflight=0.
REQ-018 In the first cycle after reset release, mem_rd SHALL be 1 and mem_raddr SHALL be RESET_PC[31:0].
REQ-019 FIFO storage contents are not reset. instr_data and instr_pc are don't-care while instr_valid=0.

Configuration
REQ-020 Macro INSTR_PREFETCH_ALIGN_CHECK_EN SHALL control redirect alignment checking.
REQ-021 With INSTR_PREFETCH_ALIGN_CHECK_EN defined:
- redirect with redirect_pc[1:0]!=0 SHALL set misalign=1 and go to HALT (no issue, FIFO empty);
- only reset or an aligned redirect SHALL leave HALT and clear misalign;
- an aligned redirect from HALT SHALL pass through FLUSH.
REQ-022 Without the macro, redirect_pc[1:0] SHALL be forced to 0 on load, misalign SHALL be tied 0, and HALT SHALL not exist.

Verification
REQ-023 Reset, then instr_ready=1, memory returns addr+0x100: mem_raddr 0,4,8,... on consecutive cycles; instr_valid first at cycle 2 with instr_pc=0, instr_data=0x100; one instruction per cycle thereafter.
REQ-024 instr_ready=0 with DEPTH=4: exactly 4 issues, count=4, mem_rd=0; instr_ready pulsed for 1 cycle: count 4->3 and exactly one new issue the next cycle.
REQ-025 Redirect to 0x200 while count=3 and inflight=1: count=0 next cycle, FLUSH bubble, mem_raddr=0x200 two cycles after redirect, first instr_pc=0x200 four cycles after redirect, no stale PC ever valid.
REQ-026 Redirect in the same cycle as a pop and a push: FIFO empty afterwards, the popped entry is not accepted (instr_valid=0 that cycle).
REQ-027 Redirect to 0xFFFF_FFFF_FFFF_FFFC: instr_pc sequence 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
REQ-028 Macro defined, redirect to 0x202: misalign=1, mem_rd=0 indefinitely; then redirect to 0x300: misalign=0, fetch resumes at 0x300. Macro undefined, redirect to 0x202: fetch at 0x200, misalign=0.
